// File: rtl/hbm_bringup_pkg.sv
// rtl/hbm_bringup_pkg.sv - shared types, fail codes and defaults for the HBM bring-up sequencer
package hbm_bringup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST  = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_NOC_SET  = 3'd2,
        ST_CAL_WAIT = 3'd3,
        ST_AXI_REL  = 3'd4,
        ST_RUN      = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_LOCK_TMO  = 3'd1;
    localparam logic [2:0] FC_CAL_FAIL  = 3'd2;
    localparam logic [2:0] FC_CAL_TMO   = 3'd3;
    localparam logic [2:0] FC_LOCK_LOST = 3'd4;
    localparam logic [2:0] FC_CAL_LOST  = 3'd5;
    localparam logic [2:0] FC_CATTRIP   = 3'd6;

    localparam int DEF_PLL_RST_CYC = 16;
    localparam int DEF_LOCK_TMO    = 1000;
    localparam int DEF_NOC_SETTLE  = 8;
    localparam int DEF_CAL_TMO     = 100000;
    localparam int DEF_MAX_RETRY   = 3;

endpackage

// File: rtl/hbm_sync2.sv
// rtl/hbm_sync2.sv - parameterized-width two-flop synchronizer with synchronous clear
module hbm_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hbm_bringup_seq.sv
// rtl/hbm_bringup_seq.sv - PLL, NoC and AXI reset sequencer with HBM calibration monitoring and retry
module hbm_bringup_seq
    import hbm_bringup_pkg::*;
#(
    parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
    parameter int LOCK_TMO    = DEF_LOCK_TMO,
    parameter int NOC_SETTLE  = DEF_NOC_SETTLE,
    parameter int CAL_TMO     = DEF_CAL_TMO,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       clk100_in_clk,
    input  logic       reset_in_reset_n,
    input  logic       iopll_locked_export,
    input  logic       hbm_local_cal_success,
    input  logic       hbm_local_cal_fail,
    input  logic       hbm_cattrip,
    input  logic       restart_req,
    output logic       iopll_reset_reset,
    output logic       noc_reset_in_reset,
    output logic       axi_reset_in_reset,
    output logic       sys_ready,
    output logic       sys_fail,
    output logic [2:0] fail_code,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(CAL_TMO + 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    logic lock_s, succ_s, fail_s, trip_s;

    hbm_sync2 #(.WIDTH(4)) u_sync (
        .clk    (clk100_in_clk),
        .resetn (reset_in_reset_n),
        .d      ({hbm_cattrip, hbm_local_cal_fail, hbm_local_cal_success, iopll_locked_export}),
        .q      ({trip_s, fail_s, succ_s, lock_s})
    );

    state_t        state, nxt_state;
    logic [TW-1:0] tmr, tmr_lim;
    logic          tmr_done, tmr_clr;
    logic [2:0]    nxt_code, retry_cause;
    logic [1:0]    nxt_retry;
    logic          retry_take;

    // The timer counts cycles spent in the current state; the last counted cycle is the limit.
    always_comb begin
        tmr_lim = '0;
        case (state)
            ST_PLL_RST:  tmr_lim = TW'(PLL_RST_CYC - 1);
            ST_PLL_WAIT: tmr_lim = TW'(LOCK_TMO - 1);
            ST_NOC_SET:  tmr_lim = TW'(NOC_SETTLE - 1);
            ST_CAL_WAIT: tmr_lim = TW'(CAL_TMO - 1);
            default:     tmr_lim = '0;
        endcase
    end

    assign tmr_done = (tmr == tmr_lim);

    always_comb begin
        nxt_state   = state;
        nxt_code    = fail_code;
        nxt_retry   = retry_cnt;
        tmr_clr     = 1'b0;
        retry_take  = 1'b0;
        retry_cause = fail_code;
        if (trip_s) begin
            nxt_state = ST_FAIL;
            nxt_code  = FC_CATTRIP;
        end else if (restart_req) begin
            nxt_state = ST_PLL_RST;
            nxt_retry = '0;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (tmr_done) nxt_state = ST_PLL_WAIT;
                end
                ST_PLL_WAIT: begin
                    if (lock_s) begin
                        nxt_state = ST_NOC_SET;
                    end else if (tmr_done) begin
                        retry_take  = 1'b1;
                        retry_cause = FC_LOCK_TMO;
                    end
                end
                ST_NOC_SET: begin
                    if (tmr_done) nxt_state = ST_CAL_WAIT;
                end
                ST_CAL_WAIT: begin
                    // A simultaneous success and fail is treated as a failure.
                    if (fail_s) begin
                        retry_take  = 1'b1;
                        retry_cause = FC_CAL_FAIL;
                    end else if (succ_s) begin
                        nxt_state = ST_AXI_REL;
                    end else if (tmr_done) begin
                        retry_take  = 1'b1;
                        retry_cause = FC_CAL_TMO;
                    end
                end
                ST_AXI_REL: nxt_state = ST_RUN;
                ST_RUN: begin
                    if (!lock_s) begin
                        retry_take  = 1'b1;
                        retry_cause = FC_LOCK_LOST;
                    end else if (!succ_s) begin
                        retry_take  = 1'b1;
                        retry_cause = FC_CAL_LOST;
                    end
                end
                default: nxt_state = state;
            endcase
            if (retry_take) begin
                nxt_code = retry_cause;
                if (retry_cnt < RETRY_MAX) begin
                    nxt_retry = retry_cnt + 2'd1;
                    nxt_state = ST_PLL_RST;
                end else begin
                    nxt_state = ST_FAIL;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge clk100_in_clk) begin
        if (!reset_in_reset_n) begin
            state              <= ST_PLL_RST;
            tmr                <= '0;
            retry_cnt          <= '0;
            fail_code          <= FC_NONE;
            iopll_reset_reset  <= 1'b1;
            noc_reset_in_reset <= 1'b1;
            axi_reset_in_reset <= 1'b1;
            sys_ready          <= 1'b0;
            sys_fail           <= 1'b0;
        end else begin
            state     <= nxt_state;
            fail_code <= nxt_code;
            retry_cnt <= nxt_retry;
            if (tmr_clr || (nxt_state != state)) tmr <= '0;
            else if (!tmr_done)                  tmr <= tmr + TW'(1);
            iopll_reset_reset  <= (nxt_state == ST_PLL_RST) || (nxt_state == ST_FAIL);
            noc_reset_in_reset <= (nxt_state inside {ST_PLL_RST, ST_PLL_WAIT, ST_NOC_SET, ST_FAIL});
            axi_reset_in_reset <= (nxt_state inside {ST_PLL_RST, ST_PLL_WAIT, ST_NOC_SET, ST_CAL_WAIT, ST_FAIL});
            sys_ready          <= (nxt_state == ST_RUN);
            sys_fail           <= (nxt_state == ST_FAIL);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hbm_bringup_seq.sv
// tb/tb_hbm_bringup_seq.sv - directed self-checking bench for hbm_bringup_seq
module tb_hbm_bringup_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic       lock = 1'b0, succ = 1'b0, cfail = 1'b0, trip = 1'b0, rst_req = 1'b0;
    logic       iopll_rst, noc_rst, axi_rst, sys_ready, sys_fail;
    logic [2:0] fail_code, state_o;
    logic [1:0] retry_cnt;

    int errors = 0;
    int checks = 0;
    bit found;
    int n;

    hbm_bringup_seq #(
        .PLL_RST_CYC(4), .LOCK_TMO(20), .NOC_SETTLE(2), .CAL_TMO(50), .MAX_RETRY(3)
    ) dut (
        .clk100_in_clk         (clk),
        .reset_in_reset_n      (resetn),
        .iopll_locked_export   (lock),
        .hbm_local_cal_success (succ),
        .hbm_local_cal_fail    (cfail),
        .hbm_cattrip           (trip),
        .restart_req           (rst_req),
        .iopll_reset_reset     (iopll_rst),
        .noc_reset_in_reset    (noc_rst),
        .axi_reset_in_reset    (axi_rst),
        .sys_ready             (sys_ready),
        .sys_fail              (sys_fail),
        .fail_code             (fail_code),
        .retry_cnt             (retry_cnt),
        .state_o               (state_o)
    );

    task automatic step(input int cyc);
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (state_o === st) hit = 1'b1;
            else step(1);
        end
    endtask

    task automatic count_state(input logic [2:0] st, output int cnt);
        cnt = 0;
        while (state_o === st && cnt < 200) begin
            cnt++;
            step(1);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; lock = 1'b0; succ = 1'b0; cfail = 1'b0; trip = 1'b0; rst_req = 1'b0;
        step(2);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(2);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if ({iopll_rst, noc_rst, axi_rst} !== 3'b111) begin errors++; $display("FAIL reset_resets: got %b expected 111", {iopll_rst, noc_rst, axi_rst}); end
        checks++; if ({sys_ready, sys_fail} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", {sys_ready, sys_fail}); end
        checks++; if ({fail_code, retry_cnt} !== 5'd0) begin errors++; $display("FAIL reset_code_retry: got %0d/%0d expected 0/0", fail_code, retry_cnt); end
        resetn = 1'b1;
    endtask

    task automatic test_nominal();
        do_reset();
        wait_state(3'd1, 20, found);
        checks++; if (state_o !== 3'd1 || {iopll_rst, noc_rst, axi_rst} !== 3'b011) begin errors++; $display("FAIL nom_pll_wait: got state %0d resets %b expected 1 011", state_o, {iopll_rst, noc_rst, axi_rst}); end
        step(5); lock = 1'b1; step(3);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL nom_noc_set: got %0d expected 2", state_o); end
        step(2);
        checks++; if (state_o !== 3'd3 || {iopll_rst, noc_rst, axi_rst} !== 3'b001) begin errors++; $display("FAIL nom_cal_wait: got state %0d resets %b expected 3 001", state_o, {iopll_rst, noc_rst, axi_rst}); end
        step(10); succ = 1'b1; step(3);
        checks++; if (state_o !== 3'd4 || axi_rst !== 1'b0) begin errors++; $display("FAIL nom_axi_rel: got state %0d axi %b expected 4 0", state_o, axi_rst); end
        step(1);
        checks++; if (state_o !== 3'd5 || sys_ready !== 1'b1 || sys_fail !== 1'b0) begin errors++; $display("FAIL nom_run: got state %0d ready %b fail %b expected 5 1 0", state_o, sys_ready, sys_fail); end
        checks++; if ({iopll_rst, noc_rst, axi_rst} !== 3'b000) begin errors++; $display("FAIL nom_run_resets: got %b expected 000", {iopll_rst, noc_rst, axi_rst}); end
        checks++; if (retry_cnt !== 2'd0 || fail_code !== 3'd0) begin errors++; $display("FAIL nom_run_code: got %0d/%0d expected 0/0", retry_cnt, fail_code); end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wait_state(3'd1, 40, found);
            count_state(3'd1, n);
            checks++; if (n !== 20) begin errors++; $display("FAIL lock_wait_cycles[%0d]: got %0d expected 20", i, n); end
            checks++; if (state_o !== 3'd0 || fail_code !== 3'd1 || retry_cnt !== i[1:0]) begin errors++; $display("FAIL lock_retry[%0d]: got state %0d code %0d retry %0d expected 0 1 %0d", i, state_o, fail_code, retry_cnt, i); end
            count_state(3'd0, n);
            checks++; if (n !== 4) begin errors++; $display("FAIL pll_rst_hold[%0d]: got %0d expected 4", i, n); end
        end
        wait_state(3'd1, 40, found);
        count_state(3'd1, n);
        checks++; if (state_o !== 3'd6 || sys_fail !== 1'b1 || sys_ready !== 1'b0) begin errors++; $display("FAIL lock_final_fail: got state %0d sys_fail %b expected 6 1", state_o, sys_fail); end
        checks++; if (fail_code !== 3'd1 || retry_cnt !== 2'd3 || {iopll_rst, noc_rst, axi_rst} !== 3'b111) begin errors++; $display("FAIL lock_final_code: got code %0d retry %0d resets %b expected 1 3 111", fail_code, retry_cnt, {iopll_rst, noc_rst, axi_rst}); end
        step(5);
        checks++; if (state_o !== 3'd6) begin errors++; $display("FAIL fail_sticky: got %0d expected 6", state_o); end
        rst_req = 1'b1; step(1); rst_req = 1'b0;
        checks++; if (state_o !== 3'd0 || retry_cnt !== 2'd0 || fail_code !== 3'd1) begin errors++; $display("FAIL restart_from_fail: got state %0d retry %0d code %0d expected 0 0 1", state_o, retry_cnt, fail_code); end
    endtask

    task automatic test_cal_both();
        do_reset();
        lock = 1'b1;
        wait_state(3'd3, 60, found);
        cfail = 1'b1; succ = 1'b1; step(3);
        checks++; if (state_o !== 3'd0 || fail_code !== 3'd2 || retry_cnt !== 2'd1) begin errors++; $display("FAIL cal_both: got state %0d code %0d retry %0d expected 0 2 1", state_o, fail_code, retry_cnt); end
        cfail = 1'b0; succ = 1'b0;
    endtask

    task automatic test_cal_timeout();
        do_reset();
        lock = 1'b1;
        wait_state(3'd3, 60, found);
        count_state(3'd3, n);
        checks++; if (n !== 50) begin errors++; $display("FAIL cal_tmo_cycles: got %0d expected 50", n); end
        checks++; if (state_o !== 3'd0 || fail_code !== 3'd3 || retry_cnt !== 2'd1) begin errors++; $display("FAIL cal_tmo: got state %0d code %0d retry %0d expected 0 3 1", state_o, fail_code, retry_cnt); end
    endtask

    task automatic test_run_loss();
        do_reset();
        lock = 1'b1; succ = 1'b1;
        wait_state(3'd5, 100, found);
        checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL loss_run_reached: got %0d expected 5", state_o); end
        lock = 1'b0; step(1); lock = 1'b1; step(2);
        checks++; if (state_o !== 3'd0 || {iopll_rst, noc_rst, axi_rst} !== 3'b111) begin errors++; $display("FAIL lock_loss: got state %0d resets %b expected 0 111", state_o, {iopll_rst, noc_rst, axi_rst}); end
        checks++; if (fail_code !== 3'd4 || retry_cnt !== 2'd1) begin errors++; $display("FAIL lock_loss_code: got %0d/%0d expected 4/1", fail_code, retry_cnt); end
        wait_state(3'd5, 100, found);
        succ = 1'b0; step(3);
        checks++; if (state_o !== 3'd0 || fail_code !== 3'd5 || retry_cnt !== 2'd2) begin errors++; $display("FAIL cal_loss: got state %0d code %0d retry %0d expected 0 5 2", state_o, fail_code, retry_cnt); end
    endtask

    task automatic test_cattrip();
        do_reset();
        lock = 1'b1; succ = 1'b1;
        wait_state(3'd5, 100, found);
        trip = 1'b1; rst_req = 1'b1; step(1); rst_req = 1'b0; step(2);
        checks++; if (state_o !== 3'd6 || fail_code !== 3'd6 || sys_fail !== 1'b1) begin errors++; $display("FAIL cattrip: got state %0d code %0d sys_fail %b expected 6 6 1", state_o, fail_code, sys_fail); end
        checks++; if ({iopll_rst, noc_rst, axi_rst} !== 3'b111 || retry_cnt !== 2'd0) begin errors++; $display("FAIL cattrip_resets: got %b retry %0d expected 111 0", {iopll_rst, noc_rst, axi_rst}, retry_cnt); end
        rst_req = 1'b1; step(1); rst_req = 1'b0; step(2);
        checks++; if (state_o !== 3'd6) begin errors++; $display("FAIL cattrip_restart_ignored: got %0d expected 6", state_o); end
        trip = 1'b0; step(3);
        rst_req = 1'b1; step(1); rst_req = 1'b0;
        checks++; if (state_o !== 3'd0 || fail_code !== 3'd6) begin errors++; $display("FAIL cattrip_clear_restart: got state %0d code %0d expected 0 6", state_o, fail_code); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock = 1'b1;
        wait_state(3'd3, 60, found);
        cfail = 1'b1; step(3); cfail = 1'b0;
        wait_state(3'd3, 60, found);
        step(2);
        checks++; if (state_o !== 3'd3 || fail_code !== 3'd2) begin errors++; $display("FAIL mid_pre: got state %0d code %0d expected 3 2", state_o, fail_code); end
        resetn = 1'b0; step(1);
        checks++; if (state_o !== 3'd0 || {iopll_rst, noc_rst, axi_rst} !== 3'b111 || {sys_ready, sys_fail} !== 2'b00) begin errors++; $display("FAIL mid_reset_out: got state %0d resets %b status %b expected 0 111 00", state_o, {iopll_rst, noc_rst, axi_rst}, {sys_ready, sys_fail}); end
        checks++; if (fail_code !== 3'd0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL mid_reset_code: got %0d/%0d expected 0/0", fail_code, retry_cnt); end
        resetn = 1'b1; succ = 1'b1;
        count_state(3'd0, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL mid_replay_pll_rst: got %0d expected 4", n); end
        wait_state(3'd5, 100, found);
        checks++; if (state_o !== 3'd5 || sys_ready !== 1'b1) begin errors++; $display("FAIL mid_replay_run: got state %0d ready %b expected 5 1", state_o, sys_ready); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_timeout();
        test_cal_both();
        test_cal_timeout();
        test_run_loss();
        test_cattrip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hbm_bringup_seq.md
HBM_BRINGUP_SEQ -- requirements
Module: hbm_bringup_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYC, default 16, cycles iopll_reset is held asserted.
REQ-002 SHALL have parameter LOCK_TMO, default 1000, max cycles to wait for PLL lock.
REQ-003 SHALL have parameter NOC_SETTLE, default 8, cycles between lock and NoC reset release.
REQ-004 SHALL have parameter CAL_TMO, default 100000, max cycles to wait for HBM calibration result.
REQ-005 SHALL have parameter MAX_RETRY, default 3, restart attempts before permanent FAIL.
REQ-006 SHALL have ports: clk100_in_clk  in  1  sole clock, 100 MHz.
REQ-007 SHALL have ports: reset_in_reset_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have ports: iopll_locked_export  in  1  PLL lock, asynchronous.
REQ-009 SHALL have ports: hbm_local_cal_success  in  1, and hbm_local_cal_fail  in  1, both asynchronous.
REQ-010 SHALL have ports: hbm_cattrip  in  1  catastrophic-temperature trip, asynchronous.
REQ-011 SHALL have ports: restart_req  in  1  single-cycle pulse requesting a full re-bringup.
REQ-012 SHALL have ports: iopll_reset_reset, noc_reset_in_reset, axi_reset_in_reset  out  1 each  active-high resets.
REQ-013 SHALL have ports: sys_ready  out  1, sys_fail  out  1, fail_code  out  3, retry_cnt  out  2, state_o  out  3.

Function
REQ-014 SHALL pass every asynchronous input through a 2-flop synchronizer; all FSM decisions use the synchronized values, so input-to-decision latency is 2 cycles.
REQ-015 SHALL implement the states PLL_RST=0, PLL_WAIT=1, NOC_SET=2, CAL_WAIT=3, AXI_REL=4, RUN=5, FAIL=6, with state_o equal to the current state encoding.
REQ-016 PLL_RST SHALL assert all three resets, count PLL_RST_CYC cycles, then go to PLL_WAIT.
REQ-017 PLL_WAIT SHALL deassert iopll_reset and go to NOC_SET on synchronized lock; on reaching LOCK_TMO cycles it SHALL take the retry path with fail_code=1.
REQ-018 NOC_SET SHALL count NOC_SETTLE cycles, then deassert noc_reset_in_reset and go to CAL_WAIT.
REQ-019 CAL_WAIT SHALL go to AXI_REL on success alone, and SHALL take the retry path on fail (fail_code=2) or on CAL_TMO expiry (fail_code=3).
REQ-020 If success and fail are both high in the same cycle, the block SHALL treat it as fail.
REQ-021 AXI_REL SHALL deassert axi_reset_in_reset and go to RUN in the next cycle.
REQ-022 In RUN, sys_ready SHALL be 1 and all resets SHALL be 0.
REQ-023 In RUN, loss of lock SHALL take the retry path with fail_code=4, and loss of cal_success SHALL take the retry path with fail_code=5.
REQ-024 Retry path: if retry_cnt is less than MAX_RETRY, the block SHALL increment retry_cnt and go to PLL_RST; otherwise it SHALL go to FAIL.
REQ-025 fail_code SHALL hold the most recent cause and SHALL be 0 until the first failure.
REQ-026 FAIL SHALL assert all resets and sys_fail=1, and SHALL stay in FAIL until restart_req or reset.
REQ-027 restart_req in any state SHALL go to PLL_RST, clear retry_cnt and clear the timers; fail_code is kept.
REQ-028 Synchronized cattrip in any state SHALL go to FAIL with fail_code=6 within 1 cycle, with priority over restart_req and every other transition.
REQ-029 While cattrip is high, restart_req SHALL be ignored.
REQ-030 Each state timer SHALL clear on state entry and saturate at its limit, with no wrap.
REQ-031 The timer width SHALL be clog2(CAL_TMO+1).
REQ-032 retry_cnt SHALL saturate at MAX_RETRY.

Reset
REQ-033 While reset_in_reset_n=0 at a clock edge, the block SHALL enter PLL_RST and clear timers, retry_cnt, fail_code and synchronizer flops.
REQ-034 During that reset, all three resets SHALL be 1, and sys_ready and sys_fail SHALL be 0.
REQ-035 Reset asserted mid-operation, including in RUN or FAIL, SHALL take effect on the next edge and restart the full sequence after release.

Structure
REQ-036 A shared package hbm_bringup_pkg SHALL hold the state enum, the fail_code constants 0-6, and the default parameter values.
REQ-037 A sub-module hbm_sync2, a parameterized-width 2-flop synchronizer, SHALL be instantiated once over {cattrip, cal_fail, cal_success, locked}.

Verification
REQ-038 Bench SHALL use PLL_RST_CYC=4, LOCK_TMO=20, NOC_SETTLE=2, CAL_TMO=50, MAX_RETRY=3.
REQ-039 Nominal: raise lock after 5 cycles in PLL_WAIT, then success after 10 cycles in CAL_WAIT -> sys_ready=1, all resets 0, retry_cnt=0, fail_code=0.
REQ-040 Lock never arrives -> 3 retries, each with PLL_RST held 4 cycles, then FAIL with sys_fail=1, fail_code=1, retry_cnt=3; a restart_req pulse -> PLL_RST with retry_cnt=0.
REQ-041 cal_fail and cal_success raised together in CAL_WAIT -> retry with fail_code=2 and retry_cnt=1.
REQ-042 In RUN, drop lock for 1 cycle -> within 3 cycles all resets are 1, fail_code=4, and the FSM re-enters PLL_RST.
REQ-043 cattrip raised in RUN concurrent with restart_req -> FAIL with fail_code=6; a restart_req while cattrip is high is ignored.
REQ-044 reset_in_reset_n pulsed low in CAL_WAIT -> all outputs take their reset values on the next edge, and a full sequence replay follows.
